// File: rtl/vpu_mem_bridge_if.sv
// Request/response bus between a CPU-side requester and vpu_mem_bridge.
interface vpu_mem_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/vpu_mem_bridge.sv
// CPU-side bridge onto the A ports of the four VPU memories (sprite, map,
// tile, palette). One request in flight; every request gets a response,
// out-of-range addresses get an error response without touching any RAM.
//
// state   | meaning
// S_IDLE  | ready for a request
// S_ISSUE | selected RAM A-port enabled for one cycle
// S_WAIT  | read data from the RAM is captured
// S_RESP  | response presented until the requester takes it
module vpu_mem_bridge #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RAM_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vpu_mem_bridge_if.slave       bus,
  output logic                  sp_en_o,
  output logic                  sp_we_o,
  output logic [RAM_ADDR_W-1:0] sp_addr_o,
  output logic [DATA_W-1:0]     sp_din_o,
  input  logic [DATA_W-1:0]     sp_dout_i,
  output logic                  map_en_o,
  output logic                  map_we_o,
  output logic [RAM_ADDR_W-1:0] map_addr_o,
  output logic [DATA_W-1:0]     map_din_o,
  input  logic [DATA_W-1:0]     map_dout_i,
  output logic                  tile_en_o,
  output logic                  tile_we_o,
  output logic [RAM_ADDR_W-1:0] tile_addr_o,
  output logic [DATA_W-1:0]     tile_din_o,
  input  logic [DATA_W-1:0]     tile_dout_i,
  output logic                  pal_en_o,
  output logic                  pal_we_o,
  output logic [RAM_ADDR_W-1:0] pal_addr_o,
  output logic [DATA_W-1:0]     pal_din_o,
  input  logic [DATA_W-1:0]     pal_dout_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_W-1:0]     rsp_rdata_q;
  logic [1:0]            sel_q;
  logic                  we_q;
  logic [3:0]            en_q;
  logic [3:0]            ram_we_q;
  logic [RAM_ADDR_W-1:0] addr_q [4];
  logic [DATA_W-1:0]     din_q  [4];

  logic                  hs_d;
  logic [1:0]            sel_d;
  logic [RAM_ADDR_W-1:0] off_d;
  logic                  range_err_d;
  logic [DATA_W-1:0]     dout_d;

  // Address decode of the request currently on the bus.
  always_comb begin
    hs_d        = bus.req_valid && req_ready_q;
    sel_d       = bus.req_addr[ADDR_W-1 -: 2];
    off_d       = bus.req_addr[RAM_ADDR_W-1:0];
    range_err_d = |bus.req_addr[ADDR_W-3:RAM_ADDR_W];
  end

  // Read data from the RAM addressed by the captured request.
  always_comb begin
    dout_d = '0;
    case (sel_q)
      2'd0:    dout_d = sp_dout_i;
      2'd1:    dout_d = map_dout_i;
      2'd2:    dout_d = tile_dout_i;
      default: dout_d = pal_dout_i;
    endcase
  end

  // Bridge FSM; every output it drives is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      en_q        <= '0;
      ram_we_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= '0;
        din_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hs_d) begin
            req_ready_q <= 1'b0;
            sel_q       <= sel_d;
            we_q        <= bus.req_we;
            if (range_err_d) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q       <= S_ISSUE;
              en_q          <= 4'b0001 << sel_d;
              ram_we_q      <= {3'b000, bus.req_we} << sel_d;
              addr_q[sel_d] <= off_d;
              din_q[sel_d]  <= bus.req_wdata;
            end
          end else begin
            // also raises ready on the first clock after reset release
            req_ready_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          en_q     <= '0;
          ram_we_q <= '0;
          if (we_q) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= dout_d;
        end
        default: begin
          if (bus.rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign sp_en_o     = en_q[0];
  assign map_en_o    = en_q[1];
  assign tile_en_o   = en_q[2];
  assign pal_en_o    = en_q[3];
  assign sp_we_o     = ram_we_q[0];
  assign map_we_o    = ram_we_q[1];
  assign tile_we_o   = ram_we_q[2];
  assign pal_we_o    = ram_we_q[3];
  assign sp_addr_o   = addr_q[0];
  assign map_addr_o  = addr_q[1];
  assign tile_addr_o = addr_q[2];
  assign pal_addr_o  = addr_q[3];
  assign sp_din_o    = din_q[0];
  assign map_din_o   = din_q[1];
  assign tile_din_o  = din_q[2];
  assign pal_din_o   = din_q[3];

endmodule

// File: tb/tb_vpu_mem_bridge.sv
// Directed bench for vpu_mem_bridge with four read-first RAM models.
module tb_vpu_mem_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vpu_mem_bridge_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  logic        sp_en, map_en, tile_en, pal_en;
  logic        sp_we, map_we, tile_we, pal_we;
  logic [11:0] sp_addr, map_addr, tile_addr, pal_addr;
  logic [31:0] sp_din, map_din, tile_din, pal_din;
  logic [31:0] sp_dout, map_dout, tile_dout, pal_dout;

  vpu_mem_bridge #(.ADDR_W(16), .DATA_W(32), .RAM_ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sp_en_o(sp_en), .sp_we_o(sp_we), .sp_addr_o(sp_addr), .sp_din_o(sp_din), .sp_dout_i(sp_dout),
    .map_en_o(map_en), .map_we_o(map_we), .map_addr_o(map_addr), .map_din_o(map_din), .map_dout_i(map_dout),
    .tile_en_o(tile_en), .tile_we_o(tile_we), .tile_addr_o(tile_addr), .tile_din_o(tile_din), .tile_dout_i(tile_dout),
    .pal_en_o(pal_en), .pal_we_o(pal_we), .pal_addr_o(pal_addr), .pal_din_o(pal_din), .pal_dout_i(pal_dout)
  );

  logic [31:0] mem_sp [4096];
  logic [31:0] mem_map [4096];
  logic [31:0] mem_tile [4096];
  logic [31:0] mem_pal [4096];

  always @(posedge clk) if (sp_en) begin
    sp_dout <= mem_sp[sp_addr];
    if (sp_we) mem_sp[sp_addr] <= sp_din;
  end
  always @(posedge clk) if (map_en) begin
    map_dout <= mem_map[map_addr];
    if (map_we) mem_map[map_addr] <= map_din;
  end
  always @(posedge clk) if (tile_en) begin
    tile_dout <= mem_tile[tile_addr];
    if (tile_we) mem_tile[tile_addr] <= tile_din;
  end
  always @(posedge clk) if (pal_en) begin
    pal_dout <= mem_pal[pal_addr];
    if (pal_we) mem_pal[pal_addr] <= pal_din;
  end

  logic [3:0]  en_v, we_v;
  logic [11:0] ram_addr [4];
  logic [31:0] ram_din [4];
  logic        any_out;
  assign en_v = {pal_en, tile_en, map_en, sp_en};
  assign we_v = {pal_we, tile_we, map_we, sp_we};
  assign ram_addr[0] = sp_addr;
  assign ram_addr[1] = map_addr;
  assign ram_addr[2] = tile_addr;
  assign ram_addr[3] = pal_addr;
  assign ram_din[0] = sp_din;
  assign ram_din[1] = map_din;
  assign ram_din[2] = tile_din;
  assign ram_din[3] = pal_din;
  assign any_out = bus.req_ready | bus.rsp_valid | bus.rsp_err | (|bus.rsp_rdata) |
                   (|en_v) | (|we_v) | (|sp_addr) | (|map_addr) | (|tile_addr) | (|pal_addr) |
                   (|sp_din) | (|map_din) | (|tile_din) | (|pal_din);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          region;   // -1: no RAM touched
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  // Wait (bounded) until req_ready is seen at a falling edge.
  task automatic wait_ready(input string name);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    if (i == 20) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  // Wait (bounded) until rsp_valid is seen at a falling edge.
  task automatic wait_rsp(input string name);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    if (i == 20) chk({name, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    int lat, extra_en;
    logic [3:0] exp_en;
    nm = $sformatf("vec%0d", idx);
    bus.req_we = v.we;
    bus.req_addr = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_valid = 1'b1;
    wait_ready(nm);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    exp_en = (v.region < 0) ? 4'b0000 : (4'b0001 << v.region);
    chk({nm, "_en_t1"}, {28'd0, en_v}, {28'd0, exp_en});
    if (v.region >= 0) begin
      chk({nm, "_we_t1"}, {28'd0, we_v}, {28'd0, (v.we ? exp_en : 4'b0000)});
      chk({nm, "_addr_t1"}, {20'd0, ram_addr[v.region]}, {20'd0, v.addr[11:0]});
      if (v.we) chk({nm, "_din_t1"}, ram_din[v.region], v.wdata);
    end
    lat = 0;
    extra_en = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) begin
        @(negedge clk);
        if (en_v != 4'b0000) extra_en++;
      end
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_latency"}, lat, v.lat);
    chk({nm, "_err"}, {31'd0, bus.rsp_err}, {31'd0, v.err});
    chk({nm, "_rdata"}, bus.rsp_rdata, v.rdata);
    chk({nm, "_extra_en"}, extra_en, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, seen;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    mem_pal[12'h010] = 32'h12345678;

    vecs[0]  = '{1'b1, 16'h4005, 32'hDEADBEEF,  1, 1'b0, 32'h0,        2};
    vecs[1]  = '{1'b0, 16'hC010, 32'h0,         3, 1'b0, 32'h12345678, 3};
    vecs[2]  = '{1'b0, 16'h1000, 32'h0,        -1, 1'b1, 32'h0,        1};
    vecs[3]  = '{1'b1, 16'h1000, 32'h55555555, -1, 1'b1, 32'h0,        1};
    vecs[4]  = '{1'b1, 16'h8FFF, 32'hCAFEF00D,  2, 1'b0, 32'h0,        2};
    vecs[5]  = '{1'b0, 16'h4005, 32'h0,         1, 1'b0, 32'hDEADBEEF, 3};
    vecs[6]  = '{1'b1, 16'h0FFF, 32'h11111111,  0, 1'b0, 32'h0,        2};
    vecs[7]  = '{1'b0, 16'h0FFF, 32'h0,         0, 1'b0, 32'h11111111, 3};
    vecs[8]  = '{1'b0, 16'hE000, 32'h0,        -1, 1'b1, 32'h0,        1};
    vecs[9]  = '{1'b1, 16'h3FFF, 32'h77777777, -1, 1'b1, 32'h0,        1};
    vecs[10] = '{1'b1, 16'hC000, 32'h000000FF,  3, 1'b0, 32'h0,        2};
    vecs[11] = '{1'b0, 16'hC000, 32'h0,         3, 1'b0, 32'h000000FF, 3};

    // Reset state
    #1 chk("reset_outputs_zero", {31'd0, any_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
    chk("rsp_valid_after_reset", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Backpressure on a tile read of 0x8FFF with a second request parked on the bus
    bus.rsp_ready = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = 16'h8FFF;
    bus.req_valid = 1'b1;
    wait_ready("bp");
    @(posedge clk);
    #1 bus.req_addr = 16'h4005;
    wait_rsp("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("bp_rdata_%0d", i), bus.rsp_rdata, 32'hCAFEF00D);
      chk($sformatf("bp_ready_%0d", i), {31'd0, bus.req_ready}, 32'd0);
      chk($sformatf("bp_no_en_%0d", i), {28'd0, en_v}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    chk("bp_ready_in_rsp_hs", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("bp_ready_after_hs", {31'd0, bus.req_ready}, 32'd1);
    chk("bp_valid_after_hs", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_map_en", {28'd0, en_v}, 32'h2);
    wait_rsp("bp2");
    chk("bp_second_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // Back-to-back write then read of sp 0x0001
    bus.req_we = 1'b1;
    bus.req_addr = 16'h0001;
    bus.req_wdata = 32'hA5A5A5A5;
    bus.req_valid = 1'b1;
    wait_ready("b2b_w");
    t0 = cyc;
    @(posedge clk);
    #1 bus.req_we = 1'b0;
    bus.req_wdata = 32'h0;
    wait_ready("b2b_r");
    t1 = cyc;
    chk("b2b_accept_gap", t1 - t0, 32'd3);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp("b2b_r");
    chk("b2b_rdata", bus.rsp_rdata, 32'hA5A5A5A5);
    chk("b2b_err", {31'd0, bus.rsp_err}, 32'd0);
    @(posedge clk);
    #1;

    // Reset while the read is in WAIT
    bus.req_we = 1'b0;
    bus.req_addr = 16'hC010;
    bus.req_valid = 1'b1;
    wait_ready("rst");
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pal_en_issue", {31'd0, pal_en}, 32'd1);
    @(negedge clk);
    chk("rst_wait_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    rst_n = 1'b0;
    #1 chk("rst_outputs_zero", {31'd0, any_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("rst_no_response", seen, 32'd0);
    chk("rst_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    run_vec(12, vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
